// File: rtl/avalon_pio_bank.sv
// avalon_pio_bank: Avalon-MM slave exposing CHANNELS PIO channels of WIDTH bits each.
// Each channel: output register with atomic set/clear, synchronised input, sticky edge capture, IRQ mask.
module avalon_pio_bank #(
  parameter int unsigned       CHANNELS    = 2,
  parameter int unsigned       WIDTH       = 32,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
  parameter int unsigned       EDGE_MODE   = 0,
  localparam int unsigned      ADDR_W      = $clog2(CHANNELS) + 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [ADDR_W-1:0]         address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  input  logic [CHANNELS*WIDTH-1:0] in_port,
  output logic [CHANNELS*WIDTH-1:0] out_port,
  output logic [CHANNELS-1:0]       out_strobe,
  output logic                      irq
);

  localparam logic [2:0] OFF_DATA = 3'd0;
  localparam logic [2:0] OFF_SET  = 3'd1;
  localparam logic [2:0] OFF_CLR  = 3'd2;
  localparam logic [2:0] OFF_IN   = 3'd3;
  localparam logic [2:0] OFF_EDGE = 3'd4;
  localparam logic [2:0] OFF_MASK = 3'd5;

  logic [CHANNELS-1:0][WIDTH-1:0] r_data;
  logic [CHANNELS-1:0][WIDTH-1:0] r_sync1;
  logic [CHANNELS-1:0][WIDTH-1:0] r_sync2;
  logic [CHANNELS-1:0][WIDTH-1:0] r_prev;
  logic [CHANNELS-1:0][WIDTH-1:0] r_edge;
  logic [CHANNELS-1:0][WIDTH-1:0] r_mask;
  logic [CHANNELS-1:0]            r_strobe;

  logic [ADDR_W-1:0]              w_chan;
  logic [2:0]                     w_off;
  logic [CHANNELS-1:0]            w_sel;
  logic                           w_wr;
  logic [WIDTH-1:0]               w_wd;
  logic [CHANNELS-1:0][WIDTH-1:0] w_event;
  logic                           w_unused;

  // Shifting keeps the channel field well-formed even when CHANNELS=1 leaves it empty.
  assign w_chan   = address >> 3;
  assign w_off    = address[2:0];
  assign w_wr     = chipselect & ~write_n;
  assign w_wd     = writedata[WIDTH-1:0];
  assign w_unused = &{1'b0, writedata};

  // An out-of-range channel index matches no select line, so it reads 0 and writes nowhere.
  always_comb begin
    w_sel = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_sel[c] = (w_chan == ADDR_W'(c));
    end
  end

  always_comb begin
    w_event = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      case (EDGE_MODE)
        0:       w_event[c] = r_sync2[c] & ~r_prev[c];
        1:       w_event[c] = ~r_sync2[c] & r_prev[c];
        default: w_event[c] = (r_sync2[c] & ~r_prev[c]) | (~r_sync2[c] & r_prev[c]);
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_data[c] <= RESET_VALUE;
      end
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_prev   <= '0;
      r_edge   <= '0;
      r_mask   <= '0;
      r_strobe <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      for (int c = 0; c < CHANNELS; c++) begin
        r_strobe[c] <= 1'b0;
        r_edge[c]   <= r_edge[c] | w_event[c];
        if (w_wr && w_sel[c]) begin
          case (w_off)
            OFF_DATA: begin
              r_data[c]   <= w_wd;
              r_strobe[c] <= 1'b1;
            end
            OFF_SET: begin
              r_data[c]   <= r_data[c] | w_wd;
              r_strobe[c] <= 1'b1;
            end
            OFF_CLR: begin
              r_data[c]   <= r_data[c] & ~w_wd;
              r_strobe[c] <= 1'b1;
            end
            // A fresh event on the same bit overrides the clear.
            OFF_EDGE: r_edge[c] <= (r_edge[c] & ~w_wd) | w_event[c];
            OFF_MASK: r_mask[c] <= w_wd;
            default:  ;
          endcase
        end
      end
    end
  end

  always_comb begin
    readdata = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_sel[c]) begin
        case (w_off)
          OFF_DATA: readdata = 32'(r_data[c]);
          OFF_IN:   readdata = 32'(r_sync2[c]);
          OFF_EDGE: readdata = 32'(r_edge[c]);
          OFF_MASK: readdata = 32'(r_mask[c]);
          default:  readdata = '0;
        endcase
      end
    end
  end

  assign out_port   = r_data;
  assign out_strobe = r_strobe;
  assign irq        = |(r_edge & r_mask);

endmodule

// File: tb/tb_avalon_pio_bank.sv
// Testbench for avalon_pio_bank (2 channels x 8 bits, reset value 0x3C, rising-edge capture).
// Directed scenarios followed by randomized traffic against a register-level reference model.
module tb_avalon_pio_bank;

  localparam logic [7:0] RV = 8'h3C;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [15:0] in_port = '0;
  logic [15:0] out_port;
  logic [1:0]  out_strobe;
  logic        irq;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  avalon_pio_bank #(
    .CHANNELS(2), .WIDTH(8), .RESET_VALUE(8'h3C), .EDGE_MODE(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .out_strobe(out_strobe), .irq(irq)
  );

  // Reference model: architectural registers plus a delay line of sampled in_port values.
  // h1/h2/h3 = in_port as sampled 1/2/3 clock edges ago; the IN register shows h2,
  // and a bit rising between the samples 3 and 2 edges ago is captured on this edge.
  logic [7:0]  m_data [2];
  logic [7:0]  m_edge [2];
  logic [7:0]  m_mask [2];
  logic [1:0]  m_strobe;
  logic [15:0] h1, h2, h3;

  function automatic bit wr_hit(input int c, input int off);
    return chipselect && !write_n && (int'(address[3]) == c) && (int'(address[2:0]) == off);
  endfunction

  function automatic logic [7:0] nxt_data(input int c);
    if (wr_hit(c, 0)) return writedata[7:0];
    if (wr_hit(c, 1)) return m_data[c] | writedata[7:0];
    if (wr_hit(c, 2)) return m_data[c] & ~writedata[7:0];
    return m_data[c];
  endfunction

  function automatic logic [7:0] nxt_edge(input int c);
    logic [15:0] rise;
    logic [7:0]  kept;
    rise = h2 & ~h3;
    kept = wr_hit(c, 4) ? (m_edge[c] & ~writedata[7:0]) : m_edge[c];
    return kept | rise[c*8 +: 8];
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < 2; c++) begin
        m_data[c] <= RV;
        m_edge[c] <= '0;
        m_mask[c] <= '0;
      end
      m_strobe <= '0;
      h1 <= '0;
      h2 <= '0;
      h3 <= '0;
    end else begin
      h1 <= in_port;
      h2 <= h1;
      h3 <= h2;
      for (int c = 0; c < 2; c++) begin
        m_data[c]   <= nxt_data(c);
        m_edge[c]   <= nxt_edge(c);
        m_mask[c]   <= wr_hit(c, 5) ? writedata[7:0] : m_mask[c];
        m_strobe[c] <= wr_hit(c, 0) || wr_hit(c, 1) || wr_hit(c, 2);
      end
    end
  end

  function automatic logic [31:0] exp_read(input logic [3:0] a);
    int c;
    c = int'(a[3]);
    case (a[2:0])
      3'd0:    return {24'h0, m_data[c]};
      3'd3:    return {24'h0, h2[c*8 +: 8]};
      3'd4:    return {24'h0, m_edge[c]};
      3'd5:    return {24'h0, m_mask[c]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_irq();
    return |(m_edge[0] & m_mask[0]) | |(m_edge[1] & m_mask[1]);
  endfunction

  // Drives one write cycle; returns on the falling edge right after the write clock edge.
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    bus_write(4'd0, 32'h55);
    bus_write(4'd8, 32'h66);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (out_port !== 16'h3C3C) begin
      failures++; $display("FAIL reset_out_port: got %h expected 3c3c", out_port);
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL reset_irq: got %b expected 0", irq);
    end
    checks++;
    if (out_strobe !== 2'b00) begin
      failures++; $display("FAIL reset_strobe: got %b expected 00", out_strobe);
    end
    @(negedge clk);
    reset_n = 1'b1;
    rd(4'd0, d);
    checks++;
    if (d !== 32'h3C) begin
      failures++; $display("FAIL reset_read_data: got %h expected 0000003c", d);
    end
    rd(4'd13, d);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL reset_read_mask: got %h expected 00000000", d);
    end
  endtask

  task automatic test_data_write();
    logic [31:0] d;
    bus_write(4'd8, 32'hFFFF_FFA5);
    checks++;
    if (out_port !== 16'hA53C) begin
      failures++; $display("FAIL data_out_port: got %h expected a53c", out_port);
    end
    checks++;
    if (out_strobe !== 2'b10) begin
      failures++; $display("FAIL data_strobe_on: got %b expected 10", out_strobe);
    end
    @(negedge clk);
    checks++;
    if (out_strobe !== 2'b00) begin
      failures++; $display("FAIL data_strobe_off: got %b expected 00", out_strobe);
    end
    rd(4'd8, d);
    checks++;
    if (d !== 32'h0000_00A5) begin
      failures++; $display("FAIL data_read: got %h expected 000000a5", d);
    end
    // IN and reserved offsets ignore writes and never strobe.
    bus_write(4'd11, 32'hFF);
    checks++;
    if (out_strobe !== 2'b00) begin
      failures++; $display("FAIL in_write_strobe: got %b expected 00", out_strobe);
    end
    bus_write(4'd14, 32'hFF);
    bus_write(4'd7, 32'hFF);
    checks++;
    if (out_port !== 16'hA53C) begin
      failures++; $display("FAIL reserved_write: got %h expected a53c", out_port);
    end
    rd(4'd14, d);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL reserved_read: got %h expected 00000000", d);
    end
  endtask

  task automatic test_set_clr();
    logic [31:0] d;
    bus_write(4'd9, 32'h0F);
    checks++;
    if (out_port[15:8] !== 8'hAF) begin
      failures++; $display("FAIL set_value: got %h expected af", out_port[15:8]);
    end
    checks++;
    if (out_strobe !== 2'b10) begin
      failures++; $display("FAIL set_strobe: got %b expected 10", out_strobe);
    end
    bus_write(4'd10, 32'hA0);
    checks++;
    if (out_port[15:8] !== 8'h0F) begin
      failures++; $display("FAIL clr_value: got %h expected 0f", out_port[15:8]);
    end
    checks++;
    if (out_strobe !== 2'b10) begin
      failures++; $display("FAIL clr_strobe: got %b expected 10", out_strobe);
    end
    rd(4'd9, d);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL set_read: got %h expected 00000000", d);
    end
    rd(4'd10, d);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL clr_read: got %h expected 00000000", d);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    address = 4'd8; writedata = 32'h11; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    checks++;
    if (out_strobe !== 2'b10) begin
      failures++; $display("FAIL b2b_strobe_first: got %b expected 10", out_strobe);
    end
    address = 4'd9; writedata = 32'h40;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    checks++;
    if (out_strobe !== 2'b10) begin
      failures++; $display("FAIL b2b_strobe_second: got %b expected 10", out_strobe);
    end
    checks++;
    if (out_port[15:8] !== 8'h51) begin
      failures++; $display("FAIL b2b_value: got %h expected 51", out_port[15:8]);
    end
    @(negedge clk);
    checks++;
    if (out_strobe !== 2'b00) begin
      failures++; $display("FAIL b2b_strobe_end: got %b expected 00", out_strobe);
    end
  endtask

  task automatic test_edge_irq();
    logic [31:0] d;
    @(negedge clk);
    in_port[3] = 1'b1;
    repeat (2) @(negedge clk);
    rd(4'd4, d);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL edge_early: got %h expected 00000000", d);
    end
    @(negedge clk);
    rd(4'd4, d);
    checks++;
    if (d !== 32'h08) begin
      failures++; $display("FAIL edge_capture: got %h expected 00000008", d);
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL edge_irq_masked: got %b expected 0", irq);
    end
    bus_write(4'd5, 32'h08);
    checks++;
    if (irq !== 1'b1) begin
      failures++; $display("FAIL mask_irq_on: got %b expected 1", irq);
    end
    bus_write(4'd4, 32'h08);
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL w1c_irq_off: got %b expected 0", irq);
    end
    rd(4'd4, d);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL w1c_edge: got %h expected 00000000", d);
    end
    @(negedge clk);
    in_port[3] = 1'b0;
    repeat (5) @(negedge clk);
    rd(4'd4, d);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL fall_ignored: got %h expected 00000000", d);
    end
  endtask

  task automatic test_simul_clear();
    logic [31:0] d;
    @(negedge clk);
    in_port[3] = 1'b1;
    repeat (3) @(negedge clk);
    in_port[3] = 1'b0;
    repeat (4) @(negedge clk);
    in_port[3] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    // This write lands on the same edge that captures the new rise.
    bus_write(4'd4, 32'h08);
    rd(4'd4, d);
    checks++;
    if (d !== 32'h08) begin
      failures++; $display("FAIL simul_edge: got %h expected 00000008", d);
    end
    checks++;
    if (irq !== 1'b1) begin
      failures++; $display("FAIL simul_irq: got %b expected 1", irq);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] d;
    @(negedge clk);
    address = 4'd0; writedata = 32'h77; chipselect = 1'b1; write_n = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chipselect = 1'b0; write_n = 1'b1;
    checks++;
    if (out_port !== 16'h3C3C) begin
      failures++; $display("FAIL midrst_out_port: got %h expected 3c3c", out_port);
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL midrst_irq: got %b expected 0", irq);
    end
    rd(4'd4, d);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL midrst_edge: got %h expected 00000000", d);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_strobe !== 2'b00) begin
        failures++; $display("FAIL midrst_strobe_cycle%0d: got %b expected 00", i, out_strobe);
      end
      rd(4'd4, d);
      checks++;
      if (d !== ((i < 3) ? 32'h0 : 32'h08)) begin
        failures++; $display("FAIL midrst_edge_cycle%0d: got %h expected %h", i, d, (i < 3) ? 32'h0 : 32'h08);
      end
    end
  endtask

  task automatic test_random();
    int b;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      checks++;
      if (out_port !== {m_data[1], m_data[0]}) begin
        failures++; $display("FAIL rand_out_port[%0d]: got %h expected %h", i, out_port, {m_data[1], m_data[0]});
      end
      checks++;
      if (out_strobe !== m_strobe) begin
        failures++; $display("FAIL rand_strobe[%0d]: got %b expected %b", i, out_strobe, m_strobe);
      end
      checks++;
      if (irq !== m_irq()) begin
        failures++; $display("FAIL rand_irq[%0d]: got %b expected %b", i, irq, m_irq());
      end
      address    = 4'($urandom_range(0, 15));
      writedata  = $urandom;
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        b = $urandom_range(0, 15);
        in_port[b] = ~in_port[b];
      end
      #1;
      checks++;
      if (readdata !== exp_read(address)) begin
        failures++; $display("FAIL rand_read[%0d] addr %0d: got %h expected %h", i, address, readdata, exp_read(address));
      end
    end
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_data_write();
    test_set_clr();
    test_back_to_back();
    test_edge_irq();
    test_simul_clear();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
